lsu_ctrl: RTL and testbench
===========================

LSU_CTRL -- requirements
Module: lsu_ctrl

Interface
REQ-001 Parameter: TIMEOUT, default 16, maximum cycles to wait for mem_rvalid before flagging an error.
REQ-002 Ports (clock and reset first):
- clk  in  1  single clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high.
- req_valid  in  1  pipeline presents a load/store.
- req_ready  out  1  the block accepts a request this cycle.
- req_we  in  1  1 = store, 0 = load.
- req_funct3  in  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-aligned.
- rsp_valid  out  1  one-cycle completion pulse.
- rsp_rdata  out  32  extended load data; 0 for stores and errors.
- rsp_err  out  1  misaligned, illegal funct3, or timeout; qualified by rsp_valid.
- mem_req  out  1  memory request.
- mem_we  out  1  memory write.
- mem_addr  out  32  word address, {req_addr[31:2],2'b00}.
- mem_be  out  4  byte enables.
- mem_wdata  out  32  lane-replicated store data.
- mem_gnt  in  1  memory accepts mem_req this cycle.
- mem_rvalid  in  1  read data valid.
- mem_rdata  in  32  read word.
- busy  out  1  high in every state except IDLE.

Function
REQ-003 The FSM SHALL have states IDLE, REQ, WAIT, RESP; req_ready = (state==IDLE).
REQ-004 IDLE: on req_valid, the block SHALL latch req_we, req_funct3, req_addr and req_wdata, and go to RESP with an error when the request is illegal, else go to REQ.
REQ-005 Illegal requests: funct3 not in {000,001,010,100,101}; store funct3 in {100,101}; H/HU with addr[0]=1; W with addr[1:0]!=0. Illegal requests SHALL NOT assert mem_req.
REQ-006 REQ: mem_req=1, and mem_we, mem_addr, mem_be and mem_wdata SHALL be held stable until mem_gnt; on gnt a store SHALL go to RESP and a load SHALL go to WAIT.
REQ-007 mem_be: B = 4'b0001<<addr[1:0]; H = 4'b0011<<addr[1:0]; W = 4'b1111; loads SHALL use the same be.
REQ-008 mem_wdata: B = {4{wdata[7:0]}}; H = {2{wdata[15:0]}}; W = wdata.
REQ-009 WAIT: on mem_rvalid the block SHALL capture the extracted lane (byte at addr[1:0]*8, half at addr[1]*16), sign-extend for B/H, zero-extend for BU/HU, and go to RESP.
REQ-010 WAIT timeout: a counter SHALL clear on entry and increment each cycle without mem_rvalid; at count==TIMEOUT-1 without rvalid the block SHALL go to RESP with rsp_err=1 and rsp_rdata=0.
REQ-011 RESP: rsp_valid=1 for exactly one cycle, then the FSM SHALL return to IDLE; the response SHALL NOT depend on a pipeline ready signal.
REQ-012 Latency: a legal store with immediate gnt SHALL produce rsp_valid 2 cycles after acceptance; a load with gnt and rvalid each one cycle after the previous step SHALL produce rsp_valid 3 cycles after acceptance; an illegal request SHALL produce rsp_valid 1 cycle after acceptance.
REQ-013 mem_rvalid outside WAIT, and mem_gnt outside REQ, SHALL be ignored.
REQ-014 mem_rvalid and timeout in the same cycle: rvalid SHALL win (data, no error).
REQ-015 rsp_rdata and rsp_err SHALL hold their last values until the next RESP; they are only meaningful with rsp_valid.

Reset
REQ-016 On reset the block SHALL set state=IDLE, mem_req=0, rsp_valid=0, rsp_err=0, rsp_rdata=0, and clear the timeout counter; mem_we, mem_be, mem_addr and mem_wdata SHALL go to 0.
REQ-017 Reset asserted in REQ or WAIT SHALL abort the access without a response; a later stale mem_rvalid SHALL be ignored per REQ-013.
REQ-018 req_ready SHALL be 0 in any cycle in which reset is high.

Verification
REQ-019 SB addr=0x103, wdata=0x000000A5, gnt immediate -> mem_addr=0x100, mem_be=4'b1000, mem_wdata=0xA5A5A5A5, rsp_valid 2 cycles after acceptance, err=0.
REQ-020 LB addr=0x202, mem_rdata=0x12F45678 -> rsp_rdata=0xFFFFFFF4; the same access as LBU -> 0x000000F4; LHU addr=0x202 -> 0x000012F4.
REQ-021 LW addr=0x106 -> rsp_valid with rsp_err=1 one cycle after acceptance, mem_req never asserted; SH with funct3=100 -> err as well.
REQ-022 LW with gnt delayed 3 cycles -> mem_req and mem_addr stable across all 4 cycles; rvalid never arrives -> rsp_err=1 after exactly TIMEOUT WAIT cycles.
REQ-023 Reset asserted in WAIT, then mem_rvalid pulses -> no rsp_valid, busy=0, req_ready=1 on the cycle after reset deasserts.
REQ-024 Back-to-back: SW followed by LW to the same address against a memory model -> the LW returns the stored word, and req_ready is low from acceptance through RESP.

Source files
------------

// File: rtl/lsu_ctrl.sv
// rtl/lsu_ctrl.sv - load/store unit controller between a pipeline and a word-wide memory port
//
// Accepts one load or store at a time from the pipeline, checks it for
// alignment and encoding, issues a single word-addressed memory request with
// byte enables and lane-replicated store data, waits for read data with a
// bounded timeout, and returns a one-cycle completion pulse with extended
// load data or an error flag.
//
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   req_valid/req_ready pipeline request handshake (ready only in IDLE)
//   req_we, req_funct3  store flag and access size/sign (B/H/W/BU/HU)
//   req_addr, req_wdata byte address and right-aligned store data
//   rsp_valid           one-cycle completion pulse
//   rsp_rdata, rsp_err  extended load data / error, held until next response
//   mem_req/mem_gnt     memory request handshake
//   mem_we, mem_addr    write flag, word-aligned address
//   mem_be, mem_wdata   byte enables, lane-replicated store data
//   mem_rvalid/mem_rdata read return
//   busy                high whenever not idle
module lsu_ctrl #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic        busy
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_RESP = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic          mem_req_q, mem_req_d;
  logic          mem_we_q, mem_we_d;
  logic [31:0]   mem_addr_q, mem_addr_d;
  logic [3:0]    mem_be_q, mem_be_d;
  logic [31:0]   mem_wdata_q, mem_wdata_d;
  logic          rsp_valid_q, rsp_valid_d;
  logic          rsp_err_q, rsp_err_d;
  logic [31:0]   rsp_rdata_q, rsp_rdata_d;
  logic [CW-1:0] cnt_q, cnt_d;
  // Byte offset and funct3 of the accepted request, kept for lane extraction.
  logic [1:0]    off_q, off_d;
  logic [2:0]    f3_q, f3_d;

  logic          illegal;
  logic [3:0]    be_calc;
  logic [31:0]   wdata_calc;
  logic [31:0]   load_ext;
  logic [7:0]    lane_b;
  logic [15:0]   lane_h;

  // Request decode from the live pipeline inputs (used only in IDLE).
  always_comb begin
    illegal    = 1'b0;
    be_calc    = 4'b1111;
    wdata_calc = req_wdata;
    case (req_funct3)
      3'b000:  illegal = 1'b0;
      3'b001:  illegal = req_addr[0];
      3'b010:  illegal = (req_addr[1:0] != 2'b00);
      3'b100:  illegal = req_we;
      3'b101:  illegal = req_we | req_addr[0];
      default: illegal = 1'b1;
    endcase
    case (req_funct3[1:0])
      2'b00: begin
        be_calc    = 4'b0001 << req_addr[1:0];
        wdata_calc = {4{req_wdata[7:0]}};
      end
      2'b01: begin
        be_calc    = 4'b0011 << req_addr[1:0];
        wdata_calc = {2{req_wdata[15:0]}};
      end
      default: begin
        be_calc    = 4'b1111;
        wdata_calc = req_wdata;
      end
    endcase
  end

  // Lane extraction and sign/zero extension of the returned word.
  always_comb begin
    lane_b   = mem_rdata[{off_q, 3'b000} +: 8];
    lane_h   = mem_rdata[{off_q[1], 4'b0000} +: 16];
    load_ext = mem_rdata;
    case (f3_q)
      3'b000:  load_ext = {{24{lane_b[7]}}, lane_b};
      3'b001:  load_ext = {{16{lane_h[15]}}, lane_h};
      3'b100:  load_ext = {24'd0, lane_b};
      3'b101:  load_ext = {16'd0, lane_h};
      default: load_ext = mem_rdata;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_be_d    = mem_be_q;
    mem_wdata_d = mem_wdata_q;
    rsp_valid_d = 1'b0;
    rsp_err_d   = rsp_err_q;
    rsp_rdata_d = rsp_rdata_q;
    cnt_d       = cnt_q;
    off_d       = off_q;
    f3_d        = f3_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          off_d       = req_addr[1:0];
          f3_d        = req_funct3;
          mem_we_d    = req_we;
          mem_addr_d  = {req_addr[31:2], 2'b00};
          mem_be_d    = be_calc;
          mem_wdata_d = wdata_calc;
          if (illegal) begin
            // Rejected without ever touching memory.
            state_d     = S_RESP;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
            rsp_rdata_d = 32'd0;
          end else begin
            state_d   = S_REQ;
            mem_req_d = 1'b1;
          end
        end
      end
      S_REQ: begin
        if (mem_gnt) begin
          mem_req_d = 1'b0;
          if (mem_we_q) begin
            state_d     = S_RESP;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b0;
            rsp_rdata_d = 32'd0;
          end else begin
            state_d = S_WAIT;
            cnt_d   = '0;
          end
        end
      end
      S_WAIT: begin
        // Data arriving on the last allowed cycle still beats the timeout.
        if (mem_rvalid) begin
          state_d     = S_RESP;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b0;
          rsp_rdata_d = load_ext;
        end else if (cnt_q == CNT_LAST) begin
          state_d     = S_RESP;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
          rsp_rdata_d = 32'd0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= 32'd0;
      mem_be_q    <= 4'd0;
      mem_wdata_q <= 32'd0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= 32'd0;
      cnt_q       <= '0;
      off_q       <= 2'd0;
      f3_q        <= 3'd0;
    end else begin
      state_q     <= state_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_be_q    <= mem_be_d;
      mem_wdata_q <= mem_wdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
      cnt_q       <= cnt_d;
      off_q       <= off_d;
      f3_q        <= f3_d;
    end
  end

  // Ready is gated by reset so no request can be taken in a reset cycle.
  assign req_ready = (state_q == S_IDLE) && !reset;
  assign busy      = (state_q != S_IDLE);
  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_rdata = rsp_rdata_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_be    = mem_be_q;
  assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
// tb/tb_lsu_ctrl.sv - self-checking bench for lsu_ctrl
module tb_lsu_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        busy;

  always #5 clk = ~clk;

  lsu_ctrl #(.TIMEOUT(16)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  int checks = 0;
  int failures = 0;

  logic [31:0] mem_model [0:63];

  int          obs_lat;
  int          obs_req_cycles;
  logic        obs_err;
  logic [31:0] obs_rdata;
  logic        obs_saw_req;
  logic        obs_stable;
  logic        obs_ready_low;
  logic        obs_we;
  logic [31:0] obs_addr;
  logic [3:0]  obs_be;
  logic [31:0] obs_wdata;

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          lat;
    logic        err;
    logic [31:0] exp_rdata;
    logic [3:0]  be;
    logic [31:0] exp_wdata;
  } vec_t;

  vec_t tbl [15];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // One request with a responding memory: grant after gd cycles of mem_req,
  // read data rvd cycles after the grant (rvd < 0: never).
  task automatic run_txn(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wdata, input int gd, input int rvd);
    int gnt_k;
    int idx;
    gnt_k = -1;
    obs_lat = -1;
    obs_req_cycles = 0;
    obs_err = 1'bx;
    obs_rdata = 32'hx;
    obs_saw_req = 1'b0;
    obs_stable = 1'b1;
    obs_ready_low = 1'b1;
    @(negedge clk);
    chk("ready_in_idle", {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
    for (int k = 1; k <= 200; k++) begin
      @(negedge clk);
      req_valid = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b0;
      if (req_ready) obs_ready_low = 1'b0;
      if (mem_req) begin
        if (!obs_saw_req) begin
          obs_saw_req = 1'b1;
          obs_we = mem_we; obs_addr = mem_addr; obs_be = mem_be; obs_wdata = mem_wdata;
        end else if (mem_we !== obs_we || mem_addr !== obs_addr || mem_be !== obs_be ||
                     mem_wdata !== obs_wdata) begin
          obs_stable = 1'b0;
        end
        obs_req_cycles++;
        if (k >= 1 + gd) begin
          mem_gnt = 1'b1;
          gnt_k = k;
          if (mem_we) begin
            idx = int'(mem_addr[7:2]);
            for (int b = 0; b < 4; b++)
              if (mem_be[b]) mem_model[idx][8*b +: 8] = mem_wdata[8*b +: 8];
          end
        end
      end
      if (gnt_k >= 0 && rvd >= 0 && k == gnt_k + 1 + rvd) begin
        mem_rvalid = 1'b1;
        mem_rdata = mem_model[int'(obs_addr[7:2])];
      end
      if (rsp_valid) begin
        obs_lat = k; obs_err = rsp_err; obs_rdata = rsp_rdata;
        mem_gnt = 1'b0; mem_rvalid = 1'b0;
        break;
      end
    end
    if (obs_lat < 0) begin
      failures++;
      $display("FAIL rsp_timeout: no rsp_valid within 200 cycles");
    end
    @(negedge clk);
    chk("rsp_one_cycle", {31'd0, rsp_valid}, 32'd0);
    chk("idle_after_rsp", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    vec_t v;
    reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'd0;
    req_addr = 32'd0; req_wdata = 32'd0; mem_gnt = 1'b0; mem_rvalid = 1'b0;
    mem_rdata = 32'd0;
    for (int i = 0; i < 64; i++) mem_model[i] = 32'd0;

    //          we    f3      addr        wdata          rdata      lat err exp_rdata     be       exp_wdata
    tbl[0]  = '{1'b1, 3'b000, 32'h103, 32'h000000A5, 32'h0,        2, 1'b0, 32'h0,        4'b1000, 32'hA5A5A5A5};
    tbl[1]  = '{1'b0, 3'b000, 32'h202, 32'h0,        32'h12F45678, 3, 1'b0, 32'hFFFFFFF4, 4'b0100, 32'h0};
    tbl[2]  = '{1'b0, 3'b100, 32'h202, 32'h0,        32'h12F45678, 3, 1'b0, 32'h000000F4, 4'b0100, 32'h0};
    tbl[3]  = '{1'b0, 3'b101, 32'h202, 32'h0,        32'h12F45678, 3, 1'b0, 32'h000012F4, 4'b1100, 32'h0};
    tbl[4]  = '{1'b0, 3'b001, 32'h200, 32'h0,        32'h12F48678, 3, 1'b0, 32'hFFFF8678, 4'b0011, 32'h0};
    tbl[5]  = '{1'b0, 3'b010, 32'h104, 32'h0,        32'hDEADBEEF, 3, 1'b0, 32'hDEADBEEF, 4'b1111, 32'h0};
    tbl[6]  = '{1'b1, 3'b001, 32'h102, 32'h1234ABCD, 32'h0,        2, 1'b0, 32'h0,        4'b1100, 32'hABCDABCD};
    tbl[7]  = '{1'b1, 3'b010, 32'h108, 32'hCAFEF00D, 32'h0,        2, 1'b0, 32'h0,        4'b1111, 32'hCAFEF00D};
    tbl[8]  = '{1'b0, 3'b010, 32'h106, 32'h0,        32'h0,        1, 1'b1, 32'h0,        4'b0000, 32'h0};
    tbl[9]  = '{1'b1, 3'b100, 32'h100, 32'h55,       32'h0,        1, 1'b1, 32'h0,        4'b0000, 32'h0};
    tbl[10] = '{1'b0, 3'b011, 32'h100, 32'h0,        32'h0,        1, 1'b1, 32'h0,        4'b0000, 32'h0};
    tbl[11] = '{1'b0, 3'b001, 32'h201, 32'h0,        32'h0,        1, 1'b1, 32'h0,        4'b0000, 32'h0};
    tbl[12] = '{1'b0, 3'b000, 32'h203, 32'h0,        32'h80FFFFFF, 3, 1'b0, 32'hFFFFFF80, 4'b1000, 32'h0};
    tbl[13] = '{1'b1, 3'b101, 32'h100, 32'h1234,     32'h0,        1, 1'b1, 32'h0,        4'b0000, 32'h0};
    tbl[14] = '{1'b0, 3'b100, 32'h201, 32'h0,        32'h0000AB00, 3, 1'b0, 32'h000000AB, 4'b0010, 32'h0};

    // Reset state, with req_ready forced low while reset is high.
    repeat (2) @(negedge clk);
    chk("rst_req_ready", {31'd0, req_ready}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_rsp_err", {31'd0, rsp_err}, 32'd0);
    chk("rst_rsp_rdata", rsp_rdata, 32'd0);
    chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_be", {28'd0, mem_be}, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    reset = 1'b0;

    for (int i = 0; i < 15; i++) begin
      v = tbl[i];
      if (!v.we) mem_model[int'(v.addr[7:2])] = v.rdata;
      run_txn(v.we, v.f3, v.addr, v.wdata, 0, v.we ? -1 : 0);
      chk($sformatf("v%0d_latency", i), obs_lat, v.lat);
      chk($sformatf("v%0d_err", i), {31'd0, obs_err}, {31'd0, v.err});
      chk($sformatf("v%0d_rdata", i), obs_rdata, v.exp_rdata);
      chk($sformatf("v%0d_mem_req_seen", i), {31'd0, obs_saw_req}, {31'd0, !v.err});
      chk($sformatf("v%0d_ready_low", i), {31'd0, obs_ready_low}, 32'd1);
      if (!v.err) begin
        chk($sformatf("v%0d_mem_be", i), {28'd0, obs_be}, {28'd0, v.be});
        chk($sformatf("v%0d_mem_addr", i), obs_addr, {v.addr[31:2], 2'b00});
        chk($sformatf("v%0d_mem_we", i), {31'd0, obs_we}, {31'd0, v.we});
        if (v.we) chk($sformatf("v%0d_mem_wdata", i), obs_wdata, v.exp_wdata);
      end
    end

    // LW, grant delayed 3 cycles, no read data: timeout after 16 WAIT cycles.
    run_txn(1'b0, 3'b010, 32'h110, 32'h0, 3, -1);
    chk("to_req_cycles", obs_req_cycles, 32'd4);
    chk("to_req_stable", {31'd0, obs_stable}, 32'd1);
    chk("to_mem_addr", obs_addr, 32'h110);
    chk("to_latency", obs_lat, 32'd21);
    chk("to_err", {31'd0, obs_err}, 32'd1);
    chk("to_rdata", obs_rdata, 32'd0);

    // Read data on the final WAIT cycle wins over the timeout.
    mem_model[int'(6'h05)] = 32'h0BADF00D;
    run_txn(1'b0, 3'b010, 32'h014, 32'h0, 0, 15);
    chk("tie_latency", obs_lat, 32'd18);
    chk("tie_err", {31'd0, obs_err}, 32'd0);
    chk("tie_rdata", obs_rdata, 32'h0BADF00D);

    // Reset during WAIT, then a stale rvalid.
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h300;
    @(negedge clk);
    req_valid = 1'b0;
    chk("rw_mem_req", {31'd0, mem_req}, 32'd1);
    mem_gnt = 1'b1;
    @(negedge clk);
    mem_gnt = 1'b0;
    chk("rw_busy_wait", {31'd0, busy}, 32'd1);
    reset = 1'b1;
    @(negedge clk);
    chk("rw_ready_in_reset", {31'd0, req_ready}, 32'd0);
    reset = 1'b0;
    mem_rvalid = 1'b1; mem_rdata = 32'h12345678;
    @(negedge clk);
    mem_rvalid = 1'b0;
    chk("rw_no_rsp", {31'd0, rsp_valid}, 32'd0);
    chk("rw_busy", {31'd0, busy}, 32'd0);
    chk("rw_ready", {31'd0, req_ready}, 32'd1);
    @(negedge clk);
    chk("rw_no_rsp_later", {31'd0, rsp_valid}, 32'd0);

    // Reset during REQ aborts the access; a stray grant in IDLE is ignored.
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010; req_addr = 32'h304;
    @(negedge clk);
    req_valid = 1'b0;
    chk("rr_mem_req", {31'd0, mem_req}, 32'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("rr_mem_req_cleared", {31'd0, mem_req}, 32'd0);
    mem_gnt = 1'b1;
    @(negedge clk);
    mem_gnt = 1'b0;
    chk("rr_busy", {31'd0, busy}, 32'd0);
    chk("rr_no_rsp", {31'd0, rsp_valid}, 32'd0);

    // Back-to-back stores then a load of the merged word from the memory model.
    run_txn(1'b1, 3'b010, 32'h040, 32'h11223344, 0, -1);
    chk("b2b_sw_err", {31'd0, obs_err}, 32'd0);
    run_txn(1'b1, 3'b000, 32'h041, 32'h00000099, 0, -1);
    chk("b2b_sb_be", {28'd0, obs_be}, 32'h2);
    run_txn(1'b0, 3'b010, 32'h040, 32'h0, 0, 0);
    chk("b2b_lw_rdata", obs_rdata, 32'h11229944);
    chk("b2b_lw_err", {31'd0, obs_err}, 32'd0);
    chk("b2b_ready_low", {31'd0, obs_ready_low}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
